// File: rtl/gobang_pkg.sv
// Gobang renderer shared types: board geometry, cell-state and pixel-code encodings.
// Shared by the piece renderer and its axis trackers.
package gobang_pkg;

  localparam int BOARD_N   = 15;
  localparam int GRID_SIZE = 31;
  localparam int ORIGIN_X  = 102;
  localparam int ORIGIN_Y  = 23;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_BLACK = 2'b01,
    CELL_WHITE = 2'b10,
    CELL_RSVD  = 2'b11
  } cell_t;

  typedef enum logic [1:0] {
    PIX_NONE  = 2'd0,
    PIX_BLACK = 2'd1,
    PIX_WHITE = 2'd2,
    PIX_RING  = 2'd3
  } pix_t;

  function automatic logic is_stone(input cell_t c);
    return (c == CELL_BLACK) || (c == CELL_WHITE);
  endfunction

  function automatic pix_t stone_code(input cell_t c);
    return (c == CELL_BLACK) ? PIX_BLACK : PIX_WHITE;
  endfunction

endpackage

// File: rtl/grid_axis_tracker.sv
// Incremental board-axis tracker: cell index, phase within the cell, in-range flag.
// Outputs are the values for the current sample; the register keeps them for the next one.
module grid_axis_tracker #(
  parameter int COUNT  = 15,
  parameter int PERIOD = 31,
  parameter int IDX_W  = 4,
  parameter int PH_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             adv,
  input  logic             clr,
  output logic [IDX_W-1:0] index,
  output logic [PH_W-1:0]  phase,
  output logic             in_range
);

  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(PERIOD - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(COUNT - 1);

  logic [IDX_W-1:0] idx_q;
  logic [PH_W-1:0]  ph_q;
  logic             in_q;

  // Next position: start beats clear, clear beats advance.
  always_comb begin
    index    = idx_q;
    phase    = ph_q;
    in_range = in_q;
    if (start) begin
      index    = '0;
      phase    = '0;
      in_range = 1'b1;
    end else if (clr) begin
      in_range = 1'b0;
    end else if (adv && in_q) begin
      if (ph_q == PH_LAST) begin
        phase = '0;
        if (idx_q == IDX_LAST) begin
          in_range = 1'b0;
        end else begin
          index = idx_q + 1'b1;
        end
      end else begin
        phase = ph_q + 1'b1;
      end
    end
  end

  // Hold the position between samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q <= '0;
      ph_q  <= '0;
      in_q  <= 1'b0;
    end else begin
      idx_q <= index;
      ph_q  <= phase;
      in_q  <= in_range;
    end
  end

endmodule

// File: rtl/piece_renderer.sv
// Pipelined Gobang stone renderer: raster position -> board cell -> stone code, 3 clk.
// Define PIECE_CURSOR_RING_EN to draw a ring around the empty cursor cell.
module piece_renderer #(
  parameter int BOARD_N   = gobang_pkg::BOARD_N,
  parameter int GRID_SIZE = gobang_pkg::GRID_SIZE,
  parameter int ORIGIN_X  = gobang_pkg::ORIGIN_X,
  parameter int ORIGIN_Y  = gobang_pkg::ORIGIN_Y,
  parameter int RADIUS    = 15,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              de,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              line_start,
  input  logic              frame_start,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [1:0]        ram_data,
  input  logic [3:0]        cursor_row,
  input  logic [3:0]        cursor_col,
  output logic              out_valid,
  output logic [1:0]        pix_code
);

  import gobang_pkg::*;

  localparam int HALF  = GRID_SIZE / 2;
  localparam int IDX_W = $clog2(BOARD_N);
  localparam int PH_W  = $clog2(GRID_SIZE);
  localparam int OFF_W = PH_W + 1;
  localparam int SQ_W  = 2 * OFF_W;
  localparam int D2_W  = SQ_W + 1;

  localparam logic [9:0] X_START = 10'(ORIGIN_X - HALF);
  localparam logic [9:0] Y_START = 10'(ORIGIN_Y - HALF);
  localparam logic signed [OFF_W-1:0] HALF_S = OFF_W'(HALF);
  localparam logic [D2_W-1:0] R2 = D2_W'(RADIUS * RADIUS);

  // Stage 0: trackers
  logic [IDX_W-1:0] col0, row0;
  logic [PH_W-1:0]  xph0, yph0;
  logic             xin0, yin0;
  logic             x_start, y_start;

  assign x_start = de && (x == X_START);
  assign y_start = line_start && (y == Y_START);

  grid_axis_tracker #(
    .COUNT  (BOARD_N),
    .PERIOD (GRID_SIZE),
    .IDX_W  (IDX_W),
    .PH_W   (PH_W)
  ) u_x_trk (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (x_start),
    .adv      (de),
    .clr      (line_start),
    .index    (col0),
    .phase    (xph0),
    .in_range (xin0)
  );

  grid_axis_tracker #(
    .COUNT  (BOARD_N),
    .PERIOD (GRID_SIZE),
    .IDX_W  (IDX_W),
    .PH_W   (PH_W)
  ) u_y_trk (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (y_start),
    .adv      (line_start),
    .clr      (frame_start),
    .index    (row0),
    .phase    (yph0),
    .in_range (yin0)
  );

  logic signed [OFF_W-1:0] dx0, dy0;
  logic [ADDR_W-1:0]       addr0;

  assign dx0   = $signed({1'b0, xph0}) - HALF_S;
  assign dy0   = $signed({1'b0, yph0}) - HALF_S;
  assign addr0 = ADDR_W'(row0) * ADDR_W'(BOARD_N) + ADDR_W'(col0);

  // Stage 1 registers
  logic                    valid1, inside1;
  logic signed [OFF_W-1:0] dx1, dy1;

  // Stage 1: latch offsets and issue the board RAM read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid1   <= 1'b0;
      inside1  <= 1'b0;
      dx1      <= '0;
      dy1      <= '0;
      ram_addr <= '0;
    end else begin
      valid1  <= de;
      inside1 <= xin0 && yin0;
      dx1     <= dx0;
      dy1     <= dy0;
      if (xin0 && yin0) begin
        ram_addr <= addr0;
      end
    end
  end

  // Stage 2 squares
  logic signed [SQ_W-1:0] dx_ext, dy_ext;
  logic signed [SQ_W-1:0] dx_sq, dy_sq;

  assign dx_ext = SQ_W'(dx1);
  assign dy_ext = SQ_W'(dy1);
  assign dx_sq  = dx_ext * dx_ext;
  assign dy_sq  = dy_ext * dy_ext;

  logic            valid2, inside2;
  cell_t           state2;
  logic [SQ_W-1:0] dx2sq, dy2sq;

  // Stage 2: capture cell state and squared offsets.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid2  <= 1'b0;
      inside2 <= 1'b0;
      state2  <= CELL_EMPTY;
      dx2sq   <= '0;
      dy2sq   <= '0;
    end else begin
      valid2  <= valid1;
      inside2 <= inside1;
      state2  <= cell_t'(ram_data);
      dx2sq   <= $unsigned(dx_sq);
      dy2sq   <= $unsigned(dy_sq);
    end
  end

`ifdef PIECE_CURSOR_RING_EN
  localparam logic [D2_W-1:0] RIN2 = D2_W'((RADIUS - 2) * (RADIUS - 2));

  logic [IDX_W-1:0] row1, col1;
  logic             hit2;
  logic             hit1;

  assign hit1 = (int'(cursor_row) < BOARD_N)
             && (int'(cursor_col) < BOARD_N)
             && (int'(cursor_row) == int'(row1))
             && (int'(cursor_col) == int'(col1));

  // Cursor path: carry the cell index and compare against the cursor.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row1 <= '0;
      col1 <= '0;
      hit2 <= 1'b0;
    end else begin
      row1 <= row0;
      col1 <= col0;
      hit2 <= hit1;
    end
  end
`else
  logic unused_cursor;
  assign unused_cursor = ^{cursor_row, cursor_col};
`endif

  // Stage 3 decision
  logic [D2_W-1:0] d2;
  logic            in_disc;
  pix_t            code;

  assign d2      = D2_W'(dx2sq) + D2_W'(dy2sq);
  assign in_disc = d2 <= R2;

  // Stones override the cursor ring.
  always_comb begin
    code = PIX_NONE;
    if (inside2 && in_disc && is_stone(state2)) begin
      code = stone_code(state2);
    end
`ifdef PIECE_CURSOR_RING_EN
    else if (inside2 && hit2 && in_disc && (d2 > RIN2)) begin
      code = PIX_RING;
    end
`endif
  end

  // Stage 3: registered outputs, blank when the slot carried no pixel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      pix_code  <= PIX_NONE;
    end else begin
      out_valid <= valid2;
      pix_code  <= valid2 ? code : PIX_NONE;
    end
  end

endmodule

// File: tb/tb_piece_renderer.sv
// Directed and raster checks for piece_renderer against a divider-based model.
// Ring expectations follow PIECE_CURSOR_RING_EN.
module tb_piece_renderer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       de = 1'b0;
  logic [9:0] x = '0;
  logic [9:0] y = '0;
  logic       line_start = 1'b0;
  logic       frame_start = 1'b0;
  logic [7:0] ram_addr;
  logic [1:0] ram_data;
  logic [3:0] cursor_row = 4'd15;
  logic [3:0] cursor_col = 4'd15;
  logic       out_valid;
  logic [1:0] pix_code;

  logic [1:0] mem [0:255];

  int vectors = 0;
  int errors = 0;

  typedef struct {
    bit       de;
    int       x;
    int       y;
    bit       ls;
    bit       fs;
    bit       rst;
    bit       ev;
    bit [1:0] ec;
  } cyc_t;

  always #5 clk = ~clk;

  assign ram_data = mem[ram_addr];

  piece_renderer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .de          (de),
    .x           (x),
    .y           (y),
    .line_start  (line_start),
    .frame_start (frame_start),
    .ram_addr    (ram_addr),
    .ram_data    (ram_data),
    .cursor_row  (cursor_row),
    .cursor_col  (cursor_col),
    .out_valid   (out_valid),
    .pix_code    (pix_code)
  );

  function automatic logic [1:0] model(input int px, input int py);
    int rx, ry, col, row, dx, dy, d2;
    logic [1:0] st;
    rx = px - 87;
    ry = py - 8;
    if (rx < 0 || rx >= 465 || ry < 0 || ry >= 465) return 2'd0;
    col = rx / 31;
    row = ry / 31;
    dx = rx % 31 - 15;
    dy = ry % 31 - 15;
    d2 = dx * dx + dy * dy;
    st = mem[row * 15 + col];
    if (d2 <= 225 && (st == 2'd1 || st == 2'd2)) return st;
`ifdef PIECE_CURSOR_RING_EN
    if (int'(cursor_row) == row && int'(cursor_col) == col
        && (st == 2'd0 || st == 2'd3) && d2 > 169 && d2 <= 225)
      return 2'd3;
`endif
    return 2'd0;
  endfunction

  task automatic clear_board();
    for (int i = 0; i < 256; i++) mem[i] = 2'd0;
  endtask

  task automatic drive(input bit d, input int px, input int py,
                       input bit ls, input bit fs);
    @(negedge clk);
    de = d;
    x = 10'(px);
    y = 10'(py);
    line_start = ls;
    frame_start = fs;
  endtask

  // Walk a frame up to (xt, yt); returns on the negedge where that pixel's output shows.
  task automatic run_to(input int yt, input int xt);
    for (int yy = 0; yy < yt; yy++) drive(1'b1, 0, yy, 1'b1, yy == 0);
    for (int xx = 0; xx <= xt; xx++)
      drive(1'b1, xx, yt, xx == 0, (xx == 0) && (yt == 0));
    drive(1'b0, xt, yt, 1'b0, 1'b0);
    drive(1'b0, xt, yt, 1'b0, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset out_valid: got %b want 0", out_valid);
    end
    vectors++;
    if (pix_code !== 2'd0) begin
      errors++;
      $display("FAIL reset pix_code: got %0d want 0", pix_code);
    end
    vectors++;
    if (ram_addr !== 8'd0) begin
      errors++;
      $display("FAIL reset ram_addr: got %0d want 0", ram_addr);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_center();
    clear_board();
    mem[0] = 2'd1;
    run_to(23, 102);
    vectors++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL center out_valid: got %b want 1", out_valid);
    end
    vectors++;
    if (pix_code !== 2'd1) begin
      errors++;
      $display("FAIL center code: got %0d want 1", pix_code);
    end
  endtask

  task automatic test_radius_edge();
    clear_board();
    mem[0] = 2'd1;
    mem[1] = 2'd2;
    run_to(23, 117);
    vectors++;
    if (pix_code !== 2'd1) begin
      errors++;
      $display("FAIL rim d2=225 code: got %0d want 1", pix_code);
    end
    run_to(34, 113);
    vectors++;
    if (pix_code !== 2'd0) begin
      errors++;
      $display("FAIL diag d2=242 code: got %0d want 0", pix_code);
    end
    run_to(23, 118);
    vectors++;
    if (pix_code !== 2'd2) begin
      errors++;
      $display("FAIL col1 dx=-15 code: got %0d want 2", pix_code);
    end
  endtask

  task automatic test_outside();
    clear_board();
    mem[0] = 2'd1;
    mem[14] = 2'd1;
    run_to(23, 86);
    vectors++;
    if (pix_code !== 2'd0) begin
      errors++;
      $display("FAIL left of board code: got %0d want 0", pix_code);
    end
    run_to(23, 551);
    vectors++;
    if (pix_code !== 2'd1) begin
      errors++;
      $display("FAIL col14 rim code: got %0d want 1", pix_code);
    end
    run_to(23, 552);
    vectors++;
    if (pix_code !== 2'd0) begin
      errors++;
      $display("FAIL right edge+1 code: got %0d want 0", pix_code);
    end
    run_to(23, 567);
    vectors++;
    if (pix_code !== 2'd0) begin
      errors++;
      $display("FAIL past last col code: got %0d want 0", pix_code);
    end
  endtask

  task automatic test_last_row();
    clear_board();
    mem[210] = 2'd1;
    run_to(472, 102);
    vectors++;
    if (pix_code !== 2'd1) begin
      errors++;
      $display("FAIL last row dy=15 code: got %0d want 1", pix_code);
    end
    run_to(473, 102);
    vectors++;
    if (pix_code !== 2'd0) begin
      errors++;
      $display("FAIL below last row code: got %0d want 0", pix_code);
    end
  endtask

  task automatic test_de_low();
    clear_board();
    mem[0] = 2'd1;
    run_to(23, 101);
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL de low out_valid: got %b want 0", out_valid);
    end
    vectors++;
    if (pix_code !== 2'd0) begin
      errors++;
      $display("FAIL de low code: got %0d want 0", pix_code);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] want;
    clear_board();
    mem[0] = 2'd1;
    mem[1] = 2'd2;
    run_to(23, 101);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i >= 3) begin
        want = (102 + i - 3 <= 117) ? 2'd1 : 2'd2;
        vectors++;
        if (out_valid !== 1'b1 || pix_code !== want) begin
          errors++;
          $display("FAIL stream x=%0d: got v=%b code=%0d want v=1 code=%0d",
                   102 + i - 3, out_valid, pix_code, want);
        end
      end
      if (i < 17) begin
        de = 1'b1;
        x = 10'(102 + i);
      end else begin
        de = 1'b0;
      end
    end
  endtask

  task automatic test_ring();
    logic [1:0] ring;
`ifdef PIECE_CURSOR_RING_EN
    ring = 2'd3;
`else
    ring = 2'd0;
`endif
    clear_board();
    cursor_row = 4'd7;
    cursor_col = 4'd7;
    run_to(240, 333);
    vectors++;
    if (pix_code !== ring) begin
      errors++;
      $display("FAIL ring d2=196 code: got %0d want %0d", pix_code, ring);
    end
    run_to(240, 331);
    vectors++;
    if (pix_code !== 2'd0) begin
      errors++;
      $display("FAIL ring d2=144 code: got %0d want 0", pix_code);
    end
    mem[112] = 2'd1;
    run_to(240, 333);
    vectors++;
    if (pix_code !== 2'd1) begin
      errors++;
      $display("FAIL stone over ring code: got %0d want 1", pix_code);
    end
  endtask

  // One frame: sparse full lines with random de gaps, optional one-cycle reset.
  task automatic raster_frame(input int rst_y, input int rst_x);
    cyc_t q[$];
    cyc_t c;
    bit dead;
    int n;
    int shown;
    dead = 1'b0;
    shown = 0;
    for (int yy = 0; yy <= 480; yy++) begin
      if (!((yy % 17) == 6 || yy == rst_y)) begin
        c = '{1'b1, 0, yy, 1'b1, yy == 0, 1'b0, 1'b1, 2'd0};
        q.push_back(c);
      end else begin
        for (int xx = 0; xx <= 580; xx++) begin
          if (xx > 0 && $urandom_range(0, 11) == 0) begin
            c = '{1'b0, xx, yy, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
            q.push_back(c);
          end
          c = '{1'b1, xx, yy, xx == 0, (xx == 0) && (yy == 0),
                1'b0, 1'b1, 2'd0};
          if (yy == rst_y && xx == rst_x) begin
            dead = 1'b1;
            c.rst = 1'b1;
            c.ev = 1'b0;
            n = q.size();
            q[n - 1].ev = 1'b0;
            q[n - 1].ec = 2'd0;
            q[n - 2].ev = 1'b0;
            q[n - 2].ec = 2'd0;
          end else if (!dead) begin
            c.ec = model(xx, yy);
          end
          q.push_back(c);
        end
      end
    end
    for (int i = 0; i < q.size() + 3; i++) begin
      @(negedge clk);
      if (i >= 3) begin
        vectors++;
        if ({out_valid, pix_code} !== {q[i - 3].ev, q[i - 3].ec}) begin
          errors++;
          if (shown < 20) begin
            shown++;
            $display("FAIL raster y=%0d x=%0d: got v=%b code=%0d want v=%b code=%0d",
                     q[i - 3].y, q[i - 3].x, out_valid, pix_code,
                     q[i - 3].ev, q[i - 3].ec);
          end
        end
      end
      if (i < q.size()) begin
        de = q[i].de;
        x = 10'(q[i].x);
        y = 10'(q[i].y);
        line_start = q[i].ls;
        frame_start = q[i].fs;
        rst_n = !q[i].rst;
      end else begin
        de = 1'b0;
        line_start = 1'b0;
        frame_start = 1'b0;
        rst_n = 1'b1;
      end
    end
  endtask

  task automatic random_board();
    clear_board();
    for (int i = 0; i < 225; i++) mem[i] = 2'($urandom_range(0, 3));
    cursor_row = 4'd3;
    cursor_col = 4'd5;
    mem[50] = 2'd0;
  endtask

  task automatic test_full_frame();
    random_board();
    raster_frame(-1, -1);
  endtask

  task automatic test_reset_mid_frame();
    random_board();
    raster_frame(210, 300);
    raster_frame(-1, -1);
  endtask

  initial begin
    clear_board();
    test_reset();
    test_center();
    test_radius_edge();
    test_outside();
    test_last_row();
    test_de_low();
    test_back_to_back();
    test_ring();
    test_full_frame();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
